// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  // Controller states: waiting for a request, shifting bits, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } sa_state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa.sv
// Gate-level one-bit full adder, purely combinational.
module FA (
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  logic ab_x_s;
  logic ab_a_s;
  logic xc_a_s;

  assign ab_x_s = A ^ B;
  assign ab_a_s = A & B;
  assign xc_a_s = ab_x_s & Ci;
  assign S      = ab_x_s ^ Ci;
  assign Co     = ab_a_s | xc_a_s;

endmodule : FA

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one operand bit pair per clock through FA, LSB first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

  sa_state_t     state_q, state_d;
  logic [N-1:0]  ra_q, ra_d;
  logic [N-1:0]  rb_q, rb_d;
  logic [N-1:0]  rs_q, rs_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          fa_s;
  logic          fa_co;

  // The single full adder always sees the operand LSBs and the running carry.
  FA u_fa (
    .A  (ra_q[0]),
    .B  (rb_q[0]),
    .Ci (carry_q),
    .S  (fa_s),
    .Co (fa_co)
  );

  // Next-state, datapath and output-pulse logic for the controller.
  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rs_d    = rs_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          ra_d    = A;
          rb_d    = B;
          carry_d = Cin;
          cnt_d   = {CW{1'b0}};
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end

      ADD: begin
        ra_d    = {1'b0, ra_q[N-1:1]};
        rb_d    = {1'b0, rb_q[N-1:1]};
        rs_d    = {fa_s, rs_q[N-1:1]};
        carry_d = fa_co;
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the completed sum; the counter stays at terminal count.
          sum_d   = {fa_s, rs_q[N-1:1]};
          cout_d  = fa_co;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // All state and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= {N{1'b0}};
      rb_q    <= {N{1'b0}};
      rs_q    <= {N{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CW{1'b0}};
      sum_q   <= {N{1'b0}};
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rs_q    <= rs_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomised self-checking bench for serial_adder (N = 8).
module tb_serial_adder;

  localparam int N = 8;

  logic         clock;
  logic         reset;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         busy;
  logic         done;
  logic [N-1:0] Sum;
  logic         Cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.N(N)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .busy  (busy),
    .done  (done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Accept one add, then count edges until done (0 if the bound expires).
  task automatic run_add(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, output int lat);
    A = a; B = b; Cin = cin; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 1; i <= N + 4; i++) begin
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #2;
    checks++;
    if ({busy, done, Cout, Sum} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_immediate: got busy=%b done=%b Cout=%b Sum=%h, want all 0", busy, done, Cout, Sum);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({busy, done, Cout, Sum} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b Cout=%b Sum=%h, want idle zeros", busy, done, Cout, Sum);
    end
  endtask

  task automatic test_basic();
    logic [N-1:0] va [3] = '{8'h0F, 8'hFF, 8'hFF};
    logic [N-1:0] vb [3] = '{8'h01, 8'h01, 8'hFF};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [N:0]   ve [3] = '{9'h010, 9'h100, 9'h1FF};
    int lat;
    for (int v = 0; v < 3; v++) begin
      run_add(va[v], vb[v], vc[v], lat);
      checks++;
      if (lat !== N) begin
        errors++;
        $display("FAIL basic_latency[%0d]: got %0d, want %0d", v, lat, N);
      end
      checks++;
      if ({Cout, Sum} !== ve[v]) begin
        errors++;
        $display("FAIL basic_sum[%0d]: got %h, want %h", v, {Cout, Sum}, ve[v]);
      end
      tick();
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL basic_idle[%0d]: got busy=%b done=%b, want 0 0", v, busy, done);
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone = 0;
    logic [N:0] res = '0;
    A = 8'h03; B = 8'h04; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    A = 8'h55; B = 8'hAA; Cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignored_busy: got %b, want 1", busy);
    end
    for (int i = 0; i < 3 * N; i++) begin
      tick();
      if (done) begin
        ndone++;
        res = {Cout, Sum};
      end
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL ignored_done_count: got %0d, want 1", ndone);
    end
    checks++;
    if (res !== 9'h007) begin
      errors++;
      $display("FAIL ignored_sum: got %h, want 007", res);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    A = 8'hFF; B = 8'hFF; Cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, Cout, Sum} !== {3'b000, 8'h00}) begin
      errors++;
      $display("FAIL midreset_clear: got busy=%b done=%b Cout=%b Sum=%h, want all 0", busy, done, Cout, Sum);
    end
    tick();
    reset = 1'b0;
    tick();
    run_add(8'h20, 8'h22, 1'b0, lat);
    checks++;
    if (lat !== N) begin
      errors++;
      $display("FAIL midreset_latency: got %0d, want %0d", lat, N);
    end
    checks++;
    if ({Cout, Sum} !== 9'h042) begin
      errors++;
      $display("FAIL midreset_sum: got %h, want 042", {Cout, Sum});
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] prev_sum;
    logic [N:0]   exp;
    int since = 0;
    int nadds = 0;
    bit first = 1'b1;
    A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
    exp = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
    start = 1'b1;
    for (int cyc = 0; cyc < 12000 && nadds < 1000; cyc++) begin
      prev_sum = Sum;
      tick();
      since++;
      checks++;
      if (Sum !== prev_sum && !done) begin
        errors++;
        $display("FAIL b2b_sum_stable: Sum changed %h -> %h without done", prev_sum, Sum);
      end
      if (done) begin
        checks++;
        if ({Cout, Sum} !== exp) begin
          errors++;
          $display("FAIL b2b_sum[%0d]: got %h, want %h", nadds, {Cout, Sum}, exp);
        end
        if (!first) begin
          checks++;
          if (since !== N + 2) begin
            errors++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles, want %0d", nadds, since, N + 2);
          end
        end
        first = 1'b0;
        since = 0;
        nadds++;
        A = N'($urandom); B = N'($urandom); Cin = 1'($urandom);
        exp = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
      end
    end
    start = 1'b0;
    checks++;
    if (nadds !== 1000) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d adds, want 1000", nadds);
    end
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final_idle: got busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_serial_adder
